// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, control-field
// enums, FSM state constants and trap causes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_ISH = 3'b001,
    IMM_S   = 3'b010,
    IMM_B   = 3'b011,
    IMM_U   = 3'b100,
    IMM_J   = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_REL = 2'b01,
    PC_ALU = 2'b10
  } pc_src_e;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_BUS     = 2'b10
  } trap_cause_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_NONE
  } instr_class_e;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath side.
interface mc_control_unit_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [31:0]           instr;
  logic                  mem_ready;
  logic                  Zero;
  logic                  LT;
  logic                  LTU;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  PCWrite;
  logic [1:0]            PCSrc;
  logic                  ALUSrcA;
  logic                  ALUSrc;
  logic [ALU_CTRL_W-1:0] ALUctrl;
  logic [2:0]            ImmSrc;
  logic [1:0]            ResultSrc;
  logic                  RegWrite;
  logic [1:0]            length;
  logic                  load_unsigned;
  logic                  trap;
  logic [1:0]            trap_cause;

  modport master (
    input  instr, mem_ready, Zero, LT, LTU,
    output MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrc, ALUctrl,
           ImmSrc, ResultSrc, RegWrite, length, load_unsigned, trap, trap_cause
  );

  modport slave (
    output instr, mem_ready, Zero, LT, LTU,
    input  MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrc, ALUctrl,
           ImmSrc, ResultSrc, RegWrite, length, load_unsigned, trap, trap_cause
  );
endinterface

// File: rtl/rv_instr_decode.sv
// Purely combinational RV32I field decode; the FSM decides in which state each field is driven.
module rv_instr_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output alu_op_e      alu_op,
  output imm_src_e     imm_src,
  output logic         alu_src,
  output logic         alu_src_a,
  output result_src_e  result_src,
  output logic [1:0]   length,
  output logic         load_unsigned,
  output instr_class_e cls,
  output logic         illegal
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_op        = ALU_ADD;
    imm_src       = IMM_I;
    alu_src       = 1'b0;
    alu_src_a     = 1'b0;
    result_src    = RES_ALU;
    length        = 2'b00;
    load_unsigned = 1'b0;
    cls           = CL_NONE;
    illegal       = 1'b1;
    case (opcode)
      OP_REG: begin
        cls     = CL_R;
        alu_op  = alu_from_f3(funct3, funct7[5]);
        // funct7=0x20 only exists for SUB and SRA
        illegal = !((funct7 == 7'h00) ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_IMM: begin
        cls     = CL_I;
        alu_src = 1'b1;
        alu_op  = alu_from_f3(funct3, funct3 == 3'b101 && funct7[5]);
        illegal = 1'b0;
        if (funct3 == 3'b001) begin
          imm_src = IMM_ISH;
          illegal = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          imm_src = IMM_ISH;
          illegal = !(funct7 == 7'h00 || funct7 == 7'h20);
        end
      end
      OP_LOAD: begin
        cls           = CL_LOAD;
        alu_src       = 1'b1;
        result_src    = RES_MEM;
        length        = funct3[1:0];
        load_unsigned = funct3[2];
        illegal       = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        cls     = CL_STORE;
        alu_src = 1'b1;
        imm_src = IMM_S;
        length  = funct3[1:0];
        illegal = (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        cls     = CL_BRANCH;
        alu_op  = ALU_SUB;
        imm_src = IMM_B;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        cls        = CL_JAL;
        imm_src    = IMM_J;
        result_src = RES_PC4;
        illegal    = 1'b0;
      end
      OP_JALR: begin
        cls        = CL_JALR;
        alu_src    = 1'b1;
        result_src = RES_PC4;
        illegal    = (funct3 != 3'b000);
      end
      OP_LUI: begin
        cls        = CL_LUI;
        imm_src    = IMM_U;
        result_src = RES_IMM;
        illegal    = 1'b0;
      end
      OP_AUIPC: begin
        cls       = CL_AUIPC;
        imm_src   = IMM_U;
        alu_src   = 1'b1;
        alu_src_a = 1'b1;
        illegal   = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with ready-handshaked memory,
// branch resolution from ALU flags, and sticky traps on illegal encodings or bus timeout.
module mc_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int ALU_CTRL_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_unit_if.master bus
);
  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  logic [2:0]       state_q, state_nx;
  logic [CNT_W-1:0] wait_q, wait_nx;
  trap_cause_e      cause_q, cause_nx;

  alu_op_e      alu_op;
  imm_src_e     imm_src;
  logic         alu_src, alu_src_a;
  result_src_e  result_src;
  logic [1:0]   length;
  logic         load_unsigned;
  instr_class_e cls;
  logic         illegal;

  logic timeout, taken, rd_nz, is_load, is_store;

  rv_instr_decode u_dec (
    .instr         (bus.instr),
    .alu_op        (alu_op),
    .imm_src       (imm_src),
    .alu_src       (alu_src),
    .alu_src_a     (alu_src_a),
    .result_src    (result_src),
    .length        (length),
    .load_unsigned (load_unsigned),
    .cls           (cls),
    .illegal       (illegal)
  );

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  assign timeout  = (wait_q == CNT_W'(MEM_WAIT_MAX - 1));
  assign taken    = branch_taken(bus.instr[14:12], bus.Zero, bus.LT, bus.LTU);
  assign rd_nz    = |bus.instr[11:7];
  assign is_load  = (cls == CL_LOAD);
  assign is_store = (cls == CL_STORE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_nx;
      wait_q  <= wait_nx;
      cause_q <= cause_nx;
    end
  end

  // Wait counter only survives while a FETCH/MEM request stays unanswered.
  always_comb begin
    state_nx = state_q;
    wait_nx  = '0;
    cause_nx = cause_q;
    unique case (state_q)
      ST_FETCH, ST_MEM: begin
        if (bus.mem_ready) begin
          if (state_q == ST_FETCH) state_nx = ST_DECODE;
          else                     state_nx = is_load ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_nx = ST_TRAP;
          cause_nx = TC_BUS;
        end else begin
          wait_nx = wait_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_nx = ST_TRAP;
          cause_nx = TC_ILLEGAL;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store)     state_nx = ST_MEM;
        else if (cls == CL_BRANCH)   state_nx = ST_FETCH;
        else                         state_nx = ST_WB;
      end
      ST_WB:   state_nx = ST_FETCH;
      ST_TRAP: state_nx = ST_TRAP;
      default: state_nx = ST_FETCH;
    endcase
  end

  // ALU/immediate controls stay valid EXEC..WB so a datapath without ALUOut still works.
  always_comb begin
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.PCSrc         = PC_SEQ;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrc        = 1'b0;
    bus.ALUctrl       = '0;
    bus.ImmSrc        = IMM_I;
    bus.ResultSrc     = RES_ALU;
    bus.RegWrite      = 1'b0;
    bus.length        = 2'b00;
    bus.load_unsigned = 1'b0;
    bus.trap          = 1'b0;
    bus.trap_cause    = TC_NONE;
    if (!rst) begin
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        bus.ALUctrl = ALU_CTRL_W'(alu_op);
        bus.ImmSrc  = imm_src;
        bus.ALUSrc  = alu_src;
        bus.ALUSrcA = alu_src_a;
      end
      if (state_q == ST_MEM || state_q == ST_WB) begin
        bus.length        = length;
        bus.load_unsigned = load_unsigned;
      end
      unique case (state_q)
        ST_FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        ST_EXEC: begin
          case (cls)
            CL_BRANCH: begin
              bus.PCWrite = taken;
              bus.PCSrc   = PC_REL;
            end
            CL_JAL: begin
              bus.PCWrite = 1'b1;
              bus.PCSrc   = PC_REL;
            end
            CL_JALR: begin
              bus.PCWrite = 1'b1;
              bus.PCSrc   = PC_ALU;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          bus.MemRead  = is_load;
          bus.MemWrite = is_store;
        end
        ST_WB: begin
          bus.RegWrite  = rd_nz;
          bus.ResultSrc = result_src;
        end
        ST_TRAP: begin
          bus.trap       = 1'b1;
          bus.trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end
endmodule
